// File: rtl/ipml_prefetch_fifo_v2_0_if.sv
// ---------------------------------------------------------------------------
// ipml_prefetch_fifo_v2_0_if
// Bundle of the write/read handshake, status flags and error pulses of the
// single-clock prefetch FIFO. clk and rst stay outside the bundle.
//
//   master : the user side (drives wr_data/wr_en/rd_en, observes the rest)
//   slave  : the FIFO side
//
// Signals
//   wr_data      write data                    wr_en        write request
//   wr_vld       write ready (= ~wr_full)      wr_full      level == capacity
//   almost_full  level >= AF threshold         rd_data      read data
//   rd_en        FWFT pop / standard request   rd_vld       read data valid
//   rd_empty     level == 0                    almost_empty level <= AE threshold
//   water_level  words held                    overflow     write-while-full pulse
//   underflow    read-with-nothing pulse
// ---------------------------------------------------------------------------
interface ipml_prefetch_fifo_v2_0_if #(
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_DATA_WIDTH  = 32
);
  logic [c_DATA_WIDTH-1:0]  wr_data;
  logic                     wr_en;
  logic                     wr_vld;
  logic                     wr_full;
  logic                     almost_full;
  logic [c_DATA_WIDTH-1:0]  rd_data;
  logic                     rd_en;
  logic                     rd_vld;
  logic                     rd_empty;
  logic                     almost_empty;
  logic [c_DEPTH_WIDTH:0]   water_level;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_vld, wr_full, almost_full, rd_data, rd_vld, rd_empty,
           almost_empty, water_level, overflow, underflow
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_vld, wr_full, almost_full, rd_data, rd_vld, rd_empty,
           almost_empty, water_level, overflow, underflow
  );
endinterface

// File: rtl/ipml_prefetch_fifo_v2_0.sv
// ---------------------------------------------------------------------------
// ipml_prefetch_fifo_v2_0
// Single-clock FIFO built from an inferred RAM with a registered read port.
// In FWFT mode (c_FWFT=1) a 2-entry prefetch buffer sits behind the RAM and
// presents the head word with a valid/ready handshake. In standard mode
// (c_FWFT=0) a read request returns data through an output register with
// a one-cycle rd_vld pulse.
//
// Ports
//   clk  single clock
//   rst  asynchronous, active-high reset
//   bus  slave modport of ipml_prefetch_fifo_v2_0_if (handshakes, flags,
//        water level, overflow/underflow pulses)
//
// water_level counts every accepted word not yet consumed, including words
// in the prefetch buffer and in the RAM read register, so total capacity is
// exactly 2^c_DEPTH_WIDTH in both modes.
// ---------------------------------------------------------------------------
module ipml_prefetch_fifo_v2_0 #(
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_FWFT        = 1,
  parameter int c_AF_LEVEL    = (1 << c_DEPTH_WIDTH) - 4,
  parameter int c_AE_LEVEL    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ipml_prefetch_fifo_v2_0_if.slave bus
);

  localparam int LP_LW  = c_DEPTH_WIDTH + 1;
  localparam int LP_CAP = 1 << c_DEPTH_WIDTH;
  localparam logic [LP_LW-1:0] LP_CAP_LV = LP_LW'(LP_CAP);
  localparam logic [LP_LW-1:0] LP_AF_LV  = LP_LW'(c_AF_LEVEL);
  localparam logic [LP_LW-1:0] LP_AE_LV  = LP_LW'(c_AE_LEVEL);

  logic [LP_LW-1:0]         r_level;
  logic [c_DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [c_DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [c_DATA_WIDTH-1:0]  r_mem [LP_CAP];
  logic [c_DATA_WIDTH-1:0]  r_ram_q;
  logic                     r_overflow;
  logic                     r_underflow;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_wr_acc;
  logic                     w_ram_rd;
  logic                     w_consume;
  logic                     w_unf_ev;
  logic                     w_rd_vld;
  logic [c_DATA_WIDTH-1:0]  w_rd_data;

  // Flags come from the registered level only, so a write while full is
  // refused even when a word leaves in the same cycle.
  assign w_full   = (r_level == LP_CAP_LV);
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = bus.wr_en & ~w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else if (w_wr_acc && !w_consume) begin
      r_level <= r_level + LP_LW'(1);
    end else if (!w_wr_acc && w_consume) begin
      r_level <= r_level - LP_LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_DEPTH_WIDTH'(1);
      if (w_ram_rd) r_rd_ptr <= r_rd_ptr + c_DEPTH_WIDTH'(1);
    end
  end

  // ---- RAM stage: storage write and registered read (contents not reset)
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data;
    if (w_ram_rd) r_ram_q <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.wr_en & w_full;
      r_underflow <= w_unf_ev;
    end
  end

  if (c_FWFT != 0) begin : g_fwft
    logic [LP_LW-1:0]        r_ram_cnt;
    logic                    r_inflight;
    logic [1:0]              r_buf_cnt;
    logic [c_DATA_WIDTH-1:0] r_buf0;
    logic [c_DATA_WIDTH-1:0] r_buf1;
    logic                    w_pop;
    logic [2:0]              w_occ;
    logic                    w_fetch;

    assign w_pop = (r_buf_cnt != 2'd0) & bus.rd_en;
    // Slots committed after this edge: buffered + in flight - leaving.
    assign w_occ   = 3'(r_buf_cnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_fetch = (r_ram_cnt != '0) && (w_occ < 3'd2);

    assign w_ram_rd  = w_fetch;
    assign w_consume = w_pop;
    assign w_unf_ev  = bus.rd_en & ~w_rd_vld;
    assign w_rd_vld  = (r_buf_cnt != 2'd0);
    assign w_rd_data = r_buf0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ram_cnt <= '0;
      end else if (w_wr_acc && !w_fetch) begin
        r_ram_cnt <= r_ram_cnt + LP_LW'(1);
      end else if (!w_wr_acc && w_fetch) begin
        r_ram_cnt <= r_ram_cnt - LP_LW'(1);
      end
    end

    // ---- prefetch stage: RAM read register -> 2-entry buffer (head in r_buf0)
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_inflight <= 1'b0;
        r_buf_cnt  <= 2'd0;
        r_buf0     <= '0;
        r_buf1     <= '0;
      end else begin
        r_inflight <= w_fetch;
        case ({w_pop, r_inflight})
          2'b10: begin
            r_buf0    <= r_buf1;
            r_buf_cnt <= r_buf_cnt - 2'd1;
          end
          2'b01: begin
            if (r_buf_cnt == 2'd0) r_buf0 <= r_ram_q;
            else                   r_buf1 <= r_ram_q;
            r_buf_cnt <= r_buf_cnt + 2'd1;
          end
          2'b11: begin
            if (r_buf_cnt == 2'd1) begin
              r_buf0 <= r_ram_q;
            end else begin
              r_buf0 <= r_buf1;
              r_buf1 <= r_ram_q;
            end
          end
          default: ;
        endcase
      end
    end
  end else begin : g_std
    logic                    r_pend;
    logic                    r_vld;
    logic [c_DATA_WIDTH-1:0] r_dout;
    logic                    w_rd_req;

    assign w_rd_req  = bus.rd_en & ~w_empty;
    assign w_ram_rd  = w_rd_req;
    assign w_consume = w_rd_req;
    assign w_unf_ev  = bus.rd_en & w_empty;
    assign w_rd_vld  = r_vld;
    assign w_rd_data = r_dout;

    // ---- output stage: RAM read register -> held output register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pend <= 1'b0;
        r_vld  <= 1'b0;
        r_dout <= '0;
      end else begin
        r_pend <= w_rd_req;
        r_vld  <= r_pend;
        if (r_pend) r_dout <= r_ram_q;
      end
    end
  end

  assign bus.wr_vld       = ~w_full;
  assign bus.wr_full      = w_full;
  assign bus.almost_full  = (r_level >= LP_AF_LV);
  assign bus.rd_empty     = w_empty;
  assign bus.almost_empty = (r_level <= LP_AE_LV);
  assign bus.water_level  = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.rd_vld       = w_rd_vld;
  assign bus.rd_data      = w_rd_data;

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0.sv
module tb_ipml_prefetch_fifo_v2_0;
  localparam int DW  = 9;
  localparam int XW  = 32;
  localparam int CAP = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ipml_prefetch_fifo_v2_0_if #(.c_DEPTH_WIDTH(DW), .c_DATA_WIDTH(XW)) bus_f ();
  ipml_prefetch_fifo_v2_0_if #(.c_DEPTH_WIDTH(DW), .c_DATA_WIDTH(XW)) bus_s ();

  ipml_prefetch_fifo_v2_0 #(
    .c_DEPTH_WIDTH(DW), .c_DATA_WIDTH(XW), .c_FWFT(1),
    .c_AF_LEVEL(CAP-4), .c_AE_LEVEL(4)
  ) u_fwft (.clk(clk), .rst(rst), .bus(bus_f));

  ipml_prefetch_fifo_v2_0 #(
    .c_DEPTH_WIDTH(DW), .c_DATA_WIDTH(XW), .c_FWFT(0),
    .c_AF_LEVEL(CAP-4), .c_AE_LEVEL(4)
  ) u_std (.clk(clk), .rst(rst), .bus(bus_s));

  int checks = 0;
  int failures = 0;
  logic [31:0] q_f[$];
  logic [31:0] q_s[$];
  int lvl_f = 0;
  int lvl_s = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0;
    bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    q_f.delete();
    q_s.delete();
    lvl_f = 0;
    lvl_s = 0;
  endtask

  task automatic test_reset();
    logic [7:0] fl;
    do_reset();
    fl = {bus_f.wr_full, bus_f.wr_vld, bus_f.almost_full, bus_f.rd_empty,
          bus_f.almost_empty, bus_f.rd_vld, bus_f.overflow, bus_f.underflow};
    checks++;
    if (fl !== 8'b0101_1000) begin
      failures++; $display("FAIL reset_flags_f: got %b expected %b", fl, 8'b0101_1000);
    end
    checks++;
    if ({bus_f.water_level, bus_f.rd_data} !== 42'd0) begin
      failures++; $display("FAIL reset_level_data_f: level %0d data %0h expected 0 0", bus_f.water_level, bus_f.rd_data);
    end
    fl = {bus_s.wr_full, bus_s.wr_vld, bus_s.almost_full, bus_s.rd_empty,
          bus_s.almost_empty, bus_s.rd_vld, bus_s.overflow, bus_s.underflow};
    checks++;
    if (fl !== 8'b0101_1000) begin
      failures++; $display("FAIL reset_flags_s: got %b expected %b", fl, 8'b0101_1000);
    end
    checks++;
    if ({bus_s.water_level, bus_s.rd_data} !== 42'd0) begin
      failures++; $display("FAIL reset_level_data_s: level %0d data %0h expected 0 0", bus_s.water_level, bus_s.rd_data);
    end
  endtask

  task automatic test_fwft_first_word();
    logic [31:0] exp;
    bus_f.wr_data = 32'hA5A5_0001;
    bus_f.wr_en = 1'b1;
    q_f.push_back(32'hA5A5_0001);
    tick();                       // E0
    bus_f.wr_en = 1'b0;
    checks++;
    if (bus_f.rd_vld !== 1'b0) begin
      failures++; $display("FAIL fw_vld_after_e0: got %b expected 0", bus_f.rd_vld);
    end
    tick();                       // E1
    checks++;
    if (bus_f.rd_vld !== 1'b0) begin
      failures++; $display("FAIL fw_vld_after_e1: got %b expected 0", bus_f.rd_vld);
    end
    tick();                       // E2
    exp = q_f[0];
    checks++;
    if ({bus_f.rd_vld, bus_f.rd_data, bus_f.water_level, bus_f.rd_empty} !== {1'b1, exp, 10'd1, 1'b0}) begin
      failures++;
      $display("FAIL fw_first_word: vld %b data %0h level %0d empty %b expected 1 %0h 1 0",
               bus_f.rd_vld, bus_f.rd_data, bus_f.water_level, bus_f.rd_empty, exp);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus_f.rd_vld, bus_f.rd_data} !== {1'b1, exp}) begin
        failures++; $display("FAIL fw_hold: cycle %0d vld %b data %0h expected 1 %0h", i, bus_f.rd_vld, bus_f.rd_data, exp);
      end
    end
    bus_f.rd_en = 1'b1;
    void'(q_f.pop_front());
    tick();
    bus_f.rd_en = 1'b0;
    checks++;
    if ({bus_f.rd_vld, bus_f.water_level, bus_f.rd_empty} !== {1'b0, 10'd0, 1'b1}) begin
      failures++; $display("FAIL fw_pop_last: vld %b level %0d empty %b expected 0 0 1", bus_f.rd_vld, bus_f.water_level, bus_f.rd_empty);
    end
  endtask

  task automatic test_fwft_fill();
    logic [12:0] exp_v, act_v;
    logic [31:0] exp;
    for (int i = 0; i < CAP; i++) begin
      bus_f.wr_data = 32'(i);
      bus_f.wr_en = 1'b1;
      q_f.push_back(32'(i));
      tick();
      exp_v = {10'(i+1), (i+1) >= CAP-4, (i+1) == CAP, (i+1) != CAP};
      act_v = {bus_f.water_level, bus_f.almost_full, bus_f.wr_full, bus_f.wr_vld};
      checks++;
      if (act_v !== exp_v) begin
        failures++; $display("FAIL fill_flags: after write %0d got %b expected %b", i, act_v, exp_v);
      end
    end
    bus_f.wr_data = 32'hDEAD_BEEF;
    bus_f.wr_en = 1'b1;
    tick();
    bus_f.wr_en = 1'b0;
    checks++;
    if ({bus_f.overflow, bus_f.water_level} !== {1'b1, 10'd512}) begin
      failures++; $display("FAIL fill_overflow: ovf %b level %0d expected 1 512", bus_f.overflow, bus_f.water_level);
    end
    tick();
    checks++;
    if ({bus_f.overflow, bus_f.water_level} !== {1'b0, 10'd512}) begin
      failures++; $display("FAIL fill_overflow_pulse: ovf %b level %0d expected 0 512", bus_f.overflow, bus_f.water_level);
    end
    bus_f.rd_en = 1'b1;
    for (int c = 0; c < 700 && q_f.size() > 0; c++) begin
      if (bus_f.rd_vld) begin
        exp = q_f.pop_front();
        checks++;
        if (bus_f.rd_data !== exp) begin
          failures++; $display("FAIL fill_drain_data: got %0h expected %0h", bus_f.rd_data, exp);
        end
      end
      tick();
    end
    bus_f.rd_en = 1'b0;
    checks++;
    if (q_f.size() != 0 || bus_f.water_level !== 10'd0) begin
      failures++; $display("FAIL fill_drain_done: left %0d level %0d expected 0 0", q_f.size(), bus_f.water_level);
    end
  endtask

  task automatic test_fwft_stream();
    logic [31:0] exp;
    bit started = 0;
    int pops = 0;
    bus_f.wr_en = 1'b1;
    bus_f.rd_en = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      bus_f.wr_data = 32'h7000_0000 + 32'(c);
      q_f.push_back(32'h7000_0000 + 32'(c));
      if (bus_f.rd_vld) started = 1;
      if (started) begin
        checks++;
        if ({bus_f.rd_vld, bus_f.water_level} !== {1'b1, 10'd3}) begin
          failures++; $display("FAIL stream_gap_level: cycle %0d vld %b level %0d expected 1 3", c, bus_f.rd_vld, bus_f.water_level);
        end
      end
      if (bus_f.rd_vld) begin
        exp = q_f.pop_front();
        pops++;
        checks++;
        if (bus_f.rd_data !== exp) begin
          failures++; $display("FAIL stream_data: got %0h expected %0h", bus_f.rd_data, exp);
        end
      end
      tick();
    end
    bus_f.wr_en = 1'b0;
    checks++;
    if (pops != 997) begin
      failures++; $display("FAIL stream_count: got %0d pops expected 997", pops);
    end
    for (int c = 0; c < 20 && q_f.size() > 0; c++) begin
      if (bus_f.rd_vld) begin
        exp = q_f.pop_front();
        checks++;
        if (bus_f.rd_data !== exp) begin
          failures++; $display("FAIL stream_drain_data: got %0h expected %0h", bus_f.rd_data, exp);
        end
      end
      tick();
    end
    bus_f.rd_en = 1'b0;
    checks++;
    if (q_f.size() != 0 || bus_f.water_level !== 10'd0) begin
      failures++; $display("FAIL stream_drain_done: left %0d level %0d expected 0 0", q_f.size(), bus_f.water_level);
    end
  endtask

  task automatic test_std_mode();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      bus_s.wr_data = 32'h5000_0000 + 32'(i);
      bus_s.wr_en = 1'b1;
      q_s.push_back(32'h5000_0000 + 32'(i));
      tick();
    end
    bus_s.wr_en = 1'b0;
    checks++;
    if (bus_s.water_level !== 10'd3) begin
      failures++; $display("FAIL std_level3: got %0d expected 3", bus_s.water_level);
    end
    for (int k = 0; k < 3; k++) begin
      exp = q_s.pop_front();
      bus_s.rd_en = 1'b1;
      tick();                     // E
      bus_s.rd_en = 1'b0;
      checks++;
      if ({bus_s.rd_vld, bus_s.water_level} !== {1'b0, 10'(2-k)}) begin
        failures++; $display("FAIL std_req: word %0d vld %b level %0d expected 0 %0d", k, bus_s.rd_vld, bus_s.water_level, 2-k);
      end
      tick();                     // E+1
      checks++;
      if ({bus_s.rd_vld, bus_s.rd_data} !== {1'b1, exp}) begin
        failures++; $display("FAIL std_data: word %0d vld %b data %0h expected 1 %0h", k, bus_s.rd_vld, bus_s.rd_data, exp);
      end
      tick();                     // E+2
      checks++;
      if ({bus_s.rd_vld, bus_s.rd_data} !== {1'b0, exp}) begin
        failures++; $display("FAIL std_hold: word %0d vld %b data %0h expected 0 %0h", k, bus_s.rd_vld, bus_s.rd_data, exp);
      end
    end
    bus_s.rd_en = 1'b1;
    tick();
    bus_s.rd_en = 1'b0;
    checks++;
    if ({bus_s.underflow, bus_s.rd_vld, bus_s.water_level} !== {1'b1, 1'b0, 10'd0}) begin
      failures++; $display("FAIL std_underflow: unf %b vld %b level %0d expected 1 0 0", bus_s.underflow, bus_s.rd_vld, bus_s.water_level);
    end
    tick();
    checks++;
    if ({bus_s.underflow, bus_s.rd_vld} !== 2'b00) begin
      failures++; $display("FAIL std_underflow_pulse: unf %b vld %b expected 0 0", bus_s.underflow, bus_s.rd_vld);
    end
  endtask

  task automatic test_random();
    int wr_pct, rd_pct, stall_f;
    logic exp_ovf_f, exp_unf_f, exp_ovf_s, exp_unf_s;
    logic ev0, ev1;
    logic [31:0] ed0, ed1, last_s, d, exp;
    logic [14:0] exp_fl, act_fl;
    logic wf, rf, ws, rs, acc, pop;
    do_reset();
    exp_ovf_f = 0; exp_unf_f = 0; exp_ovf_s = 0; exp_unf_s = 0;
    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0; last_s = '0; stall_f = 0;
    for (int c = 0; c < 20000; c++) begin
      if (((c / 1500) % 2) == 0) begin wr_pct = 75; rd_pct = 35; end
      else begin wr_pct = 35; rd_pct = 75; end
      // FWFT instance
      exp_fl = {10'(lvl_f), lvl_f == CAP, lvl_f != CAP, lvl_f >= CAP-4, lvl_f == 0, lvl_f <= 4};
      act_fl = {bus_f.water_level, bus_f.wr_full, bus_f.wr_vld, bus_f.almost_full, bus_f.rd_empty, bus_f.almost_empty};
      checks++;
      if (act_fl !== exp_fl) begin
        failures++; $display("FAIL rnd_f_flags: cycle %0d got %b expected %b", c, act_fl, exp_fl);
      end
      checks++;
      if ({bus_f.overflow, bus_f.underflow} !== {exp_ovf_f, exp_unf_f}) begin
        failures++; $display("FAIL rnd_f_err: cycle %0d got %b%b expected %b%b", c, bus_f.overflow, bus_f.underflow, exp_ovf_f, exp_unf_f);
      end
      if (lvl_f > 0 && !bus_f.rd_vld) stall_f++; else stall_f = 0;
      checks++;
      if (stall_f > 2 || (bus_f.rd_vld && lvl_f == 0)) begin
        failures++; $display("FAIL rnd_f_vld: cycle %0d vld %b level %0d stall %0d", c, bus_f.rd_vld, lvl_f, stall_f);
      end
      wf = ($urandom_range(0, 99) < wr_pct);
      rf = ($urandom_range(0, 99) < rd_pct);
      d = $urandom();
      bus_f.wr_en = wf; bus_f.rd_en = rf; bus_f.wr_data = d;
      acc = wf && (lvl_f != CAP);
      pop = rf && bus_f.rd_vld;
      if (acc) q_f.push_back(d);
      if (pop) begin
        checks++;
        if (q_f.size() == 0) begin
          failures++; $display("FAIL rnd_f_data: cycle %0d got %0h expected no data", c, bus_f.rd_data);
        end else begin
          exp = q_f.pop_front();
          if (bus_f.rd_data !== exp) begin
            failures++; $display("FAIL rnd_f_data: cycle %0d got %0h expected %0h", c, bus_f.rd_data, exp);
          end
        end
      end
      exp_ovf_f = wf && (lvl_f == CAP);
      exp_unf_f = rf && !bus_f.rd_vld;
      lvl_f = lvl_f + int'(acc) - int'(pop);
      // standard instance
      exp_fl = {10'(lvl_s), lvl_s == CAP, lvl_s != CAP, lvl_s >= CAP-4, lvl_s == 0, lvl_s <= 4};
      act_fl = {bus_s.water_level, bus_s.wr_full, bus_s.wr_vld, bus_s.almost_full, bus_s.rd_empty, bus_s.almost_empty};
      checks++;
      if (act_fl !== exp_fl) begin
        failures++; $display("FAIL rnd_s_flags: cycle %0d got %b expected %b", c, act_fl, exp_fl);
      end
      checks++;
      if ({bus_s.overflow, bus_s.underflow} !== {exp_ovf_s, exp_unf_s}) begin
        failures++; $display("FAIL rnd_s_err: cycle %0d got %b%b expected %b%b", c, bus_s.overflow, bus_s.underflow, exp_ovf_s, exp_unf_s);
      end
      if (ev1) last_s = ed1;
      checks++;
      if ({bus_s.rd_vld, bus_s.rd_data} !== {ev1, last_s}) begin
        failures++; $display("FAIL rnd_s_data: cycle %0d vld %b data %0h expected %b %0h", c, bus_s.rd_vld, bus_s.rd_data, ev1, last_s);
      end
      ws = ($urandom_range(0, 99) < wr_pct);
      rs = ($urandom_range(0, 99) < rd_pct);
      d = $urandom();
      bus_s.wr_en = ws; bus_s.rd_en = rs; bus_s.wr_data = d;
      acc = ws && (lvl_s != CAP);
      pop = rs && (lvl_s != 0);
      if (acc) q_s.push_back(d);
      ev1 = ev0; ed1 = ed0;
      ev0 = pop;
      if (pop && q_s.size() > 0) ed0 = q_s.pop_front();
      exp_ovf_s = ws && (lvl_s == CAP);
      exp_unf_s = rs && (lvl_s == 0);
      lvl_s = lvl_s + int'(acc) - int'(pop);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] fl;
    bit seen;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus_f.wr_data = 32'h100 + 32'(i);
      bus_f.wr_en = 1'b1;
      tick();
    end
    bus_f.wr_en = 1'b0;
    tick(); tick(); tick();
    bus_f.rd_en = 1'b1;
    tick(); tick();
    bus_f.rd_en = 1'b0;
    checks++;
    if (bus_f.water_level !== 10'd5) begin
      failures++; $display("FAIL mid_level5: got %0d expected 5", bus_f.water_level);
    end
    rst = 1'b1;
    #1;
    fl = {bus_f.wr_full, bus_f.wr_vld, bus_f.almost_full, bus_f.rd_empty,
          bus_f.almost_empty, bus_f.rd_vld, bus_f.overflow, bus_f.underflow};
    checks++;
    if ({fl, bus_f.water_level, bus_f.rd_data} !== {8'b0101_1000, 10'd0, 32'd0}) begin
      failures++; $display("FAIL mid_async_reset: flags %b level %0d data %0h expected 01011000 0 0", fl, bus_f.water_level, bus_f.rd_data);
    end
    tick();
    rst = 1'b0;
    q_f.delete();
    checks++;
    if ({bus_f.rd_vld, bus_f.water_level} !== {1'b0, 10'd0}) begin
      failures++; $display("FAIL mid_reset_hold: vld %b level %0d expected 0 0", bus_f.rd_vld, bus_f.water_level);
    end
    tick(); tick(); tick();
    checks++;
    if ({bus_f.rd_vld, bus_f.water_level} !== {1'b0, 10'd0}) begin
      failures++; $display("FAIL mid_no_stale: vld %b level %0d expected 0 0", bus_f.rd_vld, bus_f.water_level);
    end
    bus_f.wr_data = 32'h3C;
    bus_f.wr_en = 1'b1;
    q_f.push_back(32'h3C);
    tick();
    bus_f.wr_en = 1'b0;
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (bus_f.rd_vld) seen = 1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL mid_first_word: rd_vld never rose, got 0 expected 1");
    end else if (bus_f.rd_data !== q_f[0]) begin
      failures++; $display("FAIL mid_first_word: got %0h expected %0h", bus_f.rd_data, q_f[0]);
    end
    bus_f.rd_en = 1'b1;
    tick();
    bus_f.rd_en = 1'b0;
    tick();
    checks++;
    if ({bus_f.rd_vld, bus_f.water_level} !== {1'b0, 10'd0}) begin
      failures++; $display("FAIL mid_after_pop: vld %b level %0d expected 0 0", bus_f.rd_vld, bus_f.water_level);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_f.wr_data = '0;
    bus_s.wr_data = '0;
    idle_inputs();
    test_reset();
    test_fwft_first_word();
    test_fwft_fill();
    test_fwft_stream();
    test_std_mode();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
